axi_mem_responder: RTL

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_pkg.sv | 9 +
 rtl/axi_mem_array.sv | 27 ++
 rtl/mips_core.svh | 6 +
 rtl/axi_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared types and field widths for the AXI memory responder.
package axi_mem_pkg;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    localparam int ID_WIDTH  = 4;
    localparam int LEN_WIDTH = 4;
    localparam int LAT_WIDTH = 4;
endpackage

// File: rtl/axi_mem_array.sv
// Word storage: one synchronous read port, one write port; a same-cycle
// read and write to the same index returns the old word.
module axi_mem_array #(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/mips_core.svh
// Shared bus widths for the memory-mapped subsystem.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`endif

// File: rtl/axi_mem_responder.sv
// AXI-style burst memory slave with independent read and write FSMs,
// one outstanding transaction per channel, fixed read latency.
`include "mips_core.svh"

module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [3:0]             AWID,
    input  logic [3:0]             AWLEN,
    input  logic [`ADDR_WIDTH-1:0] AWADDR,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic                   WLAST,
    input  logic [3:0]             WID,
    input  logic [`DATA_WIDTH-1:0] WDATA,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [3:0]             BID,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [3:0]             ARID,
    input  logic [3:0]             ARLEN,
    input  logic [`ADDR_WIDTH-1:0] ARADDR,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic                   RLAST,
    output logic [3:0]             RID,
    output logic [`DATA_WIDTH-1:0] RDATA
);
    r_state_t              r_state;
    logic [LAT_WIDTH-1:0]  lat_cnt;
    logic [LEN_WIDTH-1:0]  r_len, r_beat, r_beat_nxt;
    logic [DEPTH_LOG2-1:0] r_addr, r_addr_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_valid, r_last, ar_ready, r_fire;

    w_state_t              w_state;
    logic [LEN_WIDTH-1:0]  w_len, w_beat, w_beat_nxt;
    logic [DEPTH_LOG2-1:0] w_addr;
    logic [ID_WIDTH-1:0]   w_id;
    logic                  aw_ready, w_ready, b_valid, w_fire;

    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;

    // Address bits above the memory index and WID do not affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{WID, ARADDR[`ADDR_WIDTH-1:DEPTH_LOG2], AWADDR[`ADDR_WIDTH-1:DEPTH_LOG2]};

    assign r_fire     = r_valid && RREADY;
    assign w_fire     = WVALID && w_ready;
    assign r_beat_nxt = r_beat + LEN_WIDTH'(1);
    assign w_beat_nxt = w_beat + LEN_WIDTH'(1);
    assign r_addr_nxt = r_addr + DEPTH_LOG2'(1);

    // Fetch the next word on the edge that presents it, so RDATA is ready
    // together with RVALID and simply holds while the master stalls.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = r_addr;
        if (r_state == R_WAIT && lat_cnt == '0) begin
            rd_en = 1'b1;
        end else if (r_state == R_BURST && r_fire && !r_last) begin
            rd_en  = 1'b1;
            rd_idx = r_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            lat_cnt  <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_addr   <= '0;
            r_id     <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            ar_ready <= 1'b1;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID && ar_ready) begin
                    r_id     <= ARID;
                    r_len    <= ARLEN;
                    r_addr   <= ARADDR[DEPTH_LOG2-1:0];
                    r_beat   <= '0;
                    lat_cnt  <= LAT_WIDTH'(READ_LATENCY - 1);
                    ar_ready <= 1'b0;
                    r_state  <= R_WAIT;
                end
                R_WAIT: begin
                    if (lat_cnt == '0) begin
                        r_valid <= 1'b1;
                        r_last  <= (r_len == '0);
                        r_state <= R_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_WIDTH'(1);
                    end
                end
                R_BURST: if (r_fire) begin
                    if (r_last) begin
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                        ar_ready <= 1'b1;
                        r_state  <= R_IDLE;
                    end else begin
                        r_addr <= r_addr_nxt;
                        r_beat <= r_beat_nxt;
                        r_last <= (r_beat_nxt == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Burst ends on WLAST or after AWLEN+1 beats, whichever comes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            w_len    <= '0;
            w_beat   <= '0;
            w_addr   <= '0;
            w_id     <= '0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID && aw_ready) begin
                    w_id     <= AWID;
                    w_len    <= AWLEN;
                    w_addr   <= AWADDR[DEPTH_LOG2-1:0];
                    w_beat   <= '0;
                    aw_ready <= 1'b0;
                    w_ready  <= 1'b1;
                    w_state  <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    w_addr <= w_addr + DEPTH_LOG2'(1);
                    w_beat <= w_beat_nxt;
                    if (WLAST || w_beat == w_len) begin
                        w_ready <= 1'b0;
                        b_valid <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    b_valid  <= 1'b0;
                    aw_ready <= 1'b1;
                    w_state  <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    axi_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (`DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (RDATA),
        .wr_en   (w_fire),
        .wr_addr (w_addr),
        .wr_data (WDATA)
    );

    assign ARREADY = ar_ready;
    assign RVALID  = r_valid;
    assign RLAST   = r_last;
    assign RID     = r_id;
    assign AWREADY = aw_ready;
    assign WREADY  = w_ready;
    assign BVALID  = b_valid;
    assign BID     = w_id;
endmodule
